// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS datapath (R-type, addi, lw, sw, beq).
// Latency: outputs decoded from the state register in the same cycle; lw 5, sw/R/addi 4, beq 3 cycles plus memory waits.
// Backpressure: memory states hold until i_mem_ready, aborting to FETCH after MEM_TIMEOUT wait cycles.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    input  logic       i_mem_ready,
    output logic       o_PCWrite,
    output logic       o_PCWriteCond,
    output logic       o_PCSrc,
    output logic       o_IorD,
    output logic       o_MemRead,
    output logic       o_MemWrite,
    output logic       o_IRWrite,
    output logic       o_RegDst,
    output logic       o_MemtoReg,
    output logic       o_RegWrite,
    output logic       o_ALUSrcA,
    output logic [1:0] o_ALUSrcB,
    output logic [2:0] o_ALUOp,
    output logic       o_instr_done,
    output logic       o_illegal_op,
    output logic       o_mem_err,
    output logic [3:0] o_state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Last wait count before the abort fires.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             w_mem_state;
    logic             w_timeout;

    // Only FETCH/MEMRD/MEMWR wait on memory; mem_ready wins over a coincident timeout.
    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign w_timeout   = w_mem_state && !i_mem_ready && (r_wait_cnt == TMO_LAST);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Wait counter: counts only while stalled in a memory state; every other path is a state entry and clears it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wait_cnt <= '0;
        end else if (w_mem_state && !i_mem_ready && !w_timeout) begin
            if (r_wait_cnt != '1) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:  w_next_state = i_mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (i_opcode)
                    OP_RTYPE:      w_next_state = S_EXEC;
                    OP_ADDI:       w_next_state = S_ADDIEX;
                    OP_LW, OP_SW:  w_next_state = S_MEMADR;
                    OP_BEQ:        w_next_state = S_BRANCH;
                    default:       w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR: w_next_state = (i_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next_state = i_mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  w_next_state = S_MEMWR;
            S_EXEC:   w_next_state = S_ALUWB;
            S_ADDIEX: w_next_state = S_ADDIWB;
            default:  w_next_state = S_FETCH;
        endcase
        // A timeout abandons the access; PC was not advanced so the instruction is refetched.
        if (w_timeout || (r_state == S_MEMWR && i_mem_ready)) begin
            w_next_state = S_FETCH;
        end
    end

    // Output decode; everything is forced low while reset is asserted so no write escapes a reset cycle.
    always_comb begin
        o_PCWrite     = 1'b0;
        o_PCWriteCond = 1'b0;
        o_PCSrc       = 1'b0;
        o_IorD        = 1'b0;
        o_MemRead     = 1'b0;
        o_MemWrite    = 1'b0;
        o_IRWrite     = 1'b0;
        o_RegDst      = 1'b0;
        o_MemtoReg    = 1'b0;
        o_RegWrite    = 1'b0;
        o_ALUSrcA     = 1'b0;
        o_ALUSrcB     = 2'b00;
        o_ALUOp       = 3'b000;
        o_instr_done  = 1'b0;
        o_illegal_op  = 1'b0;
        o_mem_err     = 1'b0;
        o_state       = 4'd0;
        if (!i_reset) begin
            o_state   = r_state;
            o_mem_err = w_timeout;
            case (r_state)
                S_FETCH: begin
                    o_MemRead = 1'b1;
                    o_ALUSrcB = 2'b01;
                    o_ALUOp   = ALU_ADD;
                    o_IRWrite = i_mem_ready;
                    o_PCWrite = i_mem_ready;
                end
                S_DECODE: begin
                    o_ALUSrcB = 2'b11;
                    o_ALUOp   = ALU_ADD;
                    o_illegal_op = !(i_opcode == OP_RTYPE || i_opcode == OP_ADDI ||
                                     i_opcode == OP_LW    || i_opcode == OP_SW   ||
                                     i_opcode == OP_BEQ);
                end
                S_MEMADR, S_ADDIEX: begin
                    o_ALUSrcA = 1'b1;
                    o_ALUSrcB = 2'b10;
                    o_ALUOp   = ALU_ADD;
                end
                S_MEMRD: begin
                    o_MemRead = 1'b1;
                    o_IorD    = 1'b1;
                end
                S_MEMWB: begin
                    o_MemtoReg   = 1'b1;
                    o_RegWrite   = 1'b1;
                    o_instr_done = 1'b1;
                end
                S_MEMWR: begin
                    o_MemWrite   = 1'b1;
                    o_IorD       = 1'b1;
                    o_instr_done = i_mem_ready;
                end
                S_EXEC: begin
                    o_ALUSrcA = 1'b1;
                    case (i_funct)
                        6'b100010: o_ALUOp = ALU_SUB;
                        6'b100100: o_ALUOp = ALU_AND;
                        6'b100101: o_ALUOp = ALU_OR;
                        6'b101010: o_ALUOp = ALU_SLT;
                        default:   o_ALUOp = ALU_ADD;
                    endcase
                end
                S_ALUWB: begin
                    o_RegDst     = 1'b1;
                    o_RegWrite   = 1'b1;
                    o_instr_done = 1'b1;
                end
                S_BRANCH: begin
                    o_ALUSrcA     = 1'b1;
                    o_ALUOp       = ALU_SUB;
                    o_PCWriteCond = 1'b1;
                    o_PCSrc       = 1'b1;
                    o_instr_done  = 1'b1;
                end
                S_ADDIWB: begin
                    o_RegWrite   = 1'b1;
                    o_instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class and the wait/timeout/reset corners.
// Outputs are sampled 2 time units after each rising edge; inputs change 1 unit after the edge.
// Control outputs are compared as one packed vector against hand-written constants.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, PCSrc, IorD, MemRead, MemWrite, IRWrite;
    logic       RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic       instr_done, illegal_op, mem_err;
    logic [3:0] state;

    int n_cmp = 0;
    int n_err = 0;

    // State encodings
    localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
                           MEMWR = 4'd5, EXEC = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8,
                           ADDIEX = 4'd9, ADDIWB = 4'd10;

    // Control vector layout:
    // PCW PCWC PCSrc IorD _ MR MW IRW _ RegDst M2R RW _ SrcA SrcB[1:0] _ ALUOp[2:0] _ done ill err
    localparam logic [18:0] C_ZERO     = 19'b0000_000_000_000_000_000;
    localparam logic [18:0] C_FETCH_RDY= 19'b1000_101_000_001_010_000;
    localparam logic [18:0] C_FETCH_W  = 19'b0000_100_000_001_010_000;
    localparam logic [18:0] C_DECODE   = 19'b0000_000_000_011_010_000;
    localparam logic [18:0] C_DEC_ILL  = 19'b0000_000_000_011_010_010;
    localparam logic [18:0] C_EXEC_SUB = 19'b0000_000_000_100_110_000;
    localparam logic [18:0] C_EXEC_OR  = 19'b0000_000_000_100_001_000;
    localparam logic [18:0] C_EXEC_DEF = 19'b0000_000_000_100_010_000;
    localparam logic [18:0] C_ALUWB    = 19'b0000_000_101_000_000_100;
    localparam logic [18:0] C_MEMADR   = 19'b0000_000_000_110_010_000;
    localparam logic [18:0] C_MEMRD    = 19'b0001_100_000_000_000_000;
    localparam logic [18:0] C_MEMWB    = 19'b0000_000_011_000_000_100;
    localparam logic [18:0] C_MEMWR_W  = 19'b0001_010_000_000_000_000;
    localparam logic [18:0] C_MEMWR_TO = 19'b0001_010_000_000_000_001;
    localparam logic [18:0] C_MEMWR_OK = 19'b0001_010_000_000_000_100;
    localparam logic [18:0] C_BRANCH   = 19'b0110_000_000_100_110_100;
    localparam logic [18:0] C_ADDIEX   = 19'b0000_000_000_110_010_000;
    localparam logic [18:0] C_ADDIWB   = 19'b0000_000_001_000_000_100;

    logic [18:0] ctl;
    assign ctl = {PCWrite, PCWriteCond, PCSrc, IorD, MemRead, MemWrite, IRWrite,
                  RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                  instr_done, illegal_op, mem_err};

    multicycle_control #(.MEM_TIMEOUT(15), .CNT_W(8)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_opcode      (opcode),
        .i_funct       (funct),
        .i_mem_ready   (mem_ready),
        .o_PCWrite     (PCWrite),
        .o_PCWriteCond (PCWriteCond),
        .o_PCSrc       (PCSrc),
        .o_IorD        (IorD),
        .o_MemRead     (MemRead),
        .o_MemWrite    (MemWrite),
        .o_IRWrite     (IRWrite),
        .o_RegDst      (RegDst),
        .o_MemtoReg    (MemtoReg),
        .o_RegWrite    (RegWrite),
        .o_ALUSrcA     (ALUSrcA),
        .o_ALUSrcB     (ALUSrcB),
        .o_ALUOp       (ALUOp),
        .o_instr_done  (instr_done),
        .o_illegal_op  (illegal_op),
        .o_mem_err     (mem_err),
        .o_state       (state)
    );

    always #5 clk = ~clk;

    // Advance to 1 unit after the next rising edge (input drive point).
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after input changes, then compare state and control vector.
    task automatic expect_cyc(input string tag, input logic [3:0] exp_state, input logic [18:0] exp_ctl);
        #1;
        n_cmp++;
        assert (state === exp_state) else begin
            n_err++;
            $error("FAIL %s.state observed=%0d expected=%0d", tag, state, exp_state);
        end
        n_cmp++;
        assert (ctl === exp_ctl) else begin
            n_err++;
            $error("FAIL %s.ctl observed=%b expected=%b", tag, ctl, exp_ctl);
        end
    endtask

    initial begin
        reset = 1'b1; opcode = 6'b000000; funct = 6'b100010; mem_ready = 1'b1;
        #1;
        // ---- 1. reset 3 cycles then R-type sub ----
        for (int i = 0; i < 3; i++) begin
            step();
            expect_cyc("reset", FETCH, C_ZERO);
        end
        step(); reset = 1'b0;
        expect_cyc("r.fetch", FETCH, C_FETCH_RDY);
        step(); expect_cyc("r.decode", DECODE, C_DECODE);
        step(); expect_cyc("r.exec_sub", EXEC, C_EXEC_SUB);
        step(); expect_cyc("r.aluwb", ALUWB, C_ALUWB);

        // ---- R-type or, then unknown funct defaults to add ----
        step(); funct = 6'b100101; expect_cyc("or.fetch", FETCH, C_FETCH_RDY);
        step(); expect_cyc("or.decode", DECODE, C_DECODE);
        step(); expect_cyc("or.exec", EXEC, C_EXEC_OR);
        step(); expect_cyc("or.aluwb", ALUWB, C_ALUWB);
        step(); funct = 6'b000111; expect_cyc("fdef.fetch", FETCH, C_FETCH_RDY);
        step(); expect_cyc("fdef.decode", DECODE, C_DECODE);
        step(); expect_cyc("fdef.exec", EXEC, C_EXEC_DEF);
        step(); expect_cyc("fdef.aluwb", ALUWB, C_ALUWB);

        // ---- 2. lw with 2 wait cycles in MEMRD (7 cycles) ----
        step(); opcode = 6'b100011; expect_cyc("lw.fetch", FETCH, C_FETCH_RDY);
        step(); expect_cyc("lw.decode", DECODE, C_DECODE);
        step(); expect_cyc("lw.memadr", MEMADR, C_MEMADR);
        step(); mem_ready = 1'b0; expect_cyc("lw.memrd_w0", MEMRD, C_MEMRD);
        step(); expect_cyc("lw.memrd_w1", MEMRD, C_MEMRD);
        step(); mem_ready = 1'b1; expect_cyc("lw.memrd_ok", MEMRD, C_MEMRD);
        step(); expect_cyc("lw.memwb", MEMWB, C_MEMWB);

        // ---- 3. beq ----
        step(); opcode = 6'b000100; expect_cyc("beq.fetch", FETCH, C_FETCH_RDY);
        step(); expect_cyc("beq.decode", DECODE, C_DECODE);
        step(); expect_cyc("beq.branch", BRANCH, C_BRANCH);

        // ---- addi ----
        step(); opcode = 6'b001000; expect_cyc("addi.fetch", FETCH, C_FETCH_RDY);
        step(); expect_cyc("addi.decode", DECODE, C_DECODE);
        step(); expect_cyc("addi.ex", ADDIEX, C_ADDIEX);
        step(); expect_cyc("addi.wb", ADDIWB, C_ADDIWB);

        // ---- 4. illegal opcode ----
        step(); opcode = 6'b111111; expect_cyc("ill.fetch", FETCH, C_FETCH_RDY);
        step(); expect_cyc("ill.decode", DECODE, C_DEC_ILL);

        // ---- sw at zero wait, returns straight to FETCH ----
        step(); opcode = 6'b101011; expect_cyc("sw.fetch", FETCH, C_FETCH_RDY);
        step(); expect_cyc("sw.decode", DECODE, C_DECODE);
        step(); expect_cyc("sw.memadr", MEMADR, C_MEMADR);
        step(); expect_cyc("sw.memwr_ok", MEMWR, C_MEMWR_OK);

        // ---- 5. sw with memory stuck: 15 MemWrite cycles, abort on the last ----
        step(); expect_cyc("swto.fetch", FETCH, C_FETCH_RDY);
        step(); expect_cyc("swto.decode", DECODE, C_DECODE);
        step(); expect_cyc("swto.memadr", MEMADR, C_MEMADR);
        for (int i = 0; i < 15; i++) begin
            step();
            mem_ready = 1'b0;
            expect_cyc($sformatf("swto.memwr%0d", i), MEMWR, (i == 14) ? C_MEMWR_TO : C_MEMWR_W);
        end
        step(); mem_ready = 1'b1; expect_cyc("swto.refetch", FETCH, C_FETCH_RDY);

        // ---- 6. reset during MEMWR ----
        step(); expect_cyc("swrst.decode", DECODE, C_DECODE);
        step(); expect_cyc("swrst.memadr", MEMADR, C_MEMADR);
        step(); mem_ready = 1'b0; expect_cyc("swrst.memwr", MEMWR, C_MEMWR_W);
        step(); expect_cyc("swrst.memwr1", MEMWR, C_MEMWR_W);
        reset = 1'b1; expect_cyc("swrst.in_reset", FETCH, C_ZERO);
        // Counter must restart from 0: 14 stall cycles with no abort, then ready wins at the last count.
        step(); reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (i == 14) mem_ready = 1'b1;
            expect_cyc($sformatf("rst.fetch%0d", i), FETCH, (i == 14) ? C_FETCH_RDY : C_FETCH_W);
            step();
        end
        opcode = 6'b111111;
        expect_cyc("rst.decode", DECODE, C_DEC_ILL);
        step(); expect_cyc("end.fetch", FETCH, C_FETCH_RDY);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
